// File: rtl/can_btl_pkg.sv
// rtl/can_btl_pkg.sv - CAN bit timing widths, segment states and default timing config
package can_btl_pkg;

  localparam int BRP_W   = 6;
  localparam int TSEG1_W = 4;
  localparam int TSEG2_W = 3;
  localparam int SJW_W   = 2;
  // One extra bit so tseg1 + ext never wraps
  localparam int TQ_W    = ((TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W) + 1;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_TSEG1 = 2'd1,
    ST_TSEG2 = 2'd2
  } btl_state_e;

  localparam logic [BRP_W-1:0]   DEF_BRP   = '0;
  localparam logic [TSEG1_W-1:0] DEF_TSEG1 = 4'd7;
  localparam logic [TSEG2_W-1:0] DEF_TSEG2 = 3'd4;
  localparam logic [SJW_W-1:0]   DEF_SJW   = 2'd0;

endpackage

// File: rtl/can_btl_if.sv
// rtl/can_btl_if.sv - bus pin, timing config and strobe bundle between controller and bit timing
interface can_btl_if;
  import can_btl_pkg::*;

  logic               rx_in;
  logic               hard_sync_en;
  logic [BRP_W-1:0]   cfg_brp;
  logic [TSEG1_W-1:0] cfg_tseg1;
  logic [TSEG2_W-1:0] cfg_tseg2;
  logic [SJW_W-1:0]   cfg_sjw;
  logic               sample_point;
  logic               tx_point;
  logic               rx_bit;
  logic               hard_sync;

  modport master (
    output rx_in, hard_sync_en, cfg_brp, cfg_tseg1, cfg_tseg2, cfg_sjw,
    input  sample_point, tx_point, rx_bit, hard_sync
  );

  modport slave (
    input  rx_in, hard_sync_en, cfg_brp, cfg_tseg1, cfg_tseg2, cfg_sjw,
    output sample_point, tx_point, rx_bit, hard_sync
  );

endinterface

// File: rtl/can_btl_rx_sync.sv
// rtl/can_btl_rx_sync.sv - two-flop RX synchroniser with recessive-to-dominant edge detect
module can_btl_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rx_s,
  output logic fall
);

  logic s1_q, s1_d, s2_q, s2_d, d_q, d_d;

  always_comb begin
    s1_d = rx_in;
    s2_d = s1_q;
    d_d  = s2_q;
  end

  // Reset to recessive so leaving reset never looks like an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      d_q  <= 1'b1;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      d_q  <= d_d;
    end
  end

  assign rx_s = s2_q;
  assign fall = d_q & ~s2_q;

endmodule

// File: rtl/can_btl.sv
// rtl/can_btl.sv - CAN bit timing: tq prescaler, SYNC/TSEG1/TSEG2 sequencer, hard sync and resync
module can_btl
  import can_btl_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  can_btl_if.slave bus
);

  btl_state_e         state_q, state_d;
  logic [BRP_W-1:0]   pcnt_q, pcnt_d, brp_q, brp_d;
  logic [TSEG1_W-1:0] tseg1_q, tseg1_d;
  logic [TSEG2_W-1:0] tseg2_q, tseg2_d;
  logic [SJW_W-1:0]   sjw_q, sjw_d;
  logic [TQ_W-1:0]    tq_cnt_q, tq_cnt_d, ext_q, ext_d, shr_q, shr_d;
  logic               sync_allowed_q, sync_allowed_d;
  logic               sample_point_q, sample_point_d, tx_point_q, tx_point_d;
  logic               rx_bit_q, rx_bit_d, hard_sync_q, hard_sync_d;

  logic               rx_s, fall, tq_tick, enter_sync, sync_ok;
  logic [TQ_W-1:0]    ext_n, shr_n, e_val, r_val, sjw_p1;

  can_btl_rx_sync u_rx_sync (
    .clk   (clk),
    .rst   (rst),
    .rx_in (bus.rx_in),
    .rx_s  (rx_s),
    .fall  (fall)
  );

  assign tq_tick = (pcnt_q == brp_q);
  assign sync_ok = fall & sync_allowed_q;

  always_comb begin
    state_d        = state_q;
    pcnt_d         = tq_tick ? '0 : pcnt_q + 1'b1;
    tq_cnt_d       = tq_cnt_q;
    ext_d          = ext_q;
    shr_d          = shr_q;
    brp_d          = brp_q;
    tseg1_d        = tseg1_q;
    tseg2_d        = tseg2_q;
    sjw_d          = sjw_q;
    sync_allowed_d = sync_allowed_q;
    sample_point_d = 1'b0;
    tx_point_d     = 1'b0;
    hard_sync_d    = 1'b0;
    rx_bit_d       = rx_bit_q;
    enter_sync     = 1'b0;
    sjw_p1         = TQ_W'(sjw_q) + 1'b1;
    e_val          = tq_cnt_q + 1'b1;
    r_val          = TQ_W'(tseg2_q) - tq_cnt_q;
    ext_n          = ext_q;
    shr_n          = shr_q;

    if (sync_ok && bus.hard_sync_en) begin
      state_d        = ST_TSEG1;
      pcnt_d         = '0;
      tq_cnt_d       = '0;
      ext_d          = '0;
      shr_d          = '0;
      hard_sync_d    = 1'b1;
      sync_allowed_d = 1'b0;
    end else if (sync_ok && state_q == ST_TSEG2 && r_val <= TQ_W'(sjw_q)) begin
      // Edge late enough in phase 2 that the bit simply ends here
      enter_sync     = 1'b1;
      pcnt_d         = '0;
      sync_allowed_d = 1'b0;
    end else begin
      if (sync_ok && state_q == ST_TSEG1) begin
        ext_n          = (e_val < sjw_p1) ? e_val : sjw_p1;
        sync_allowed_d = 1'b0;
      end
      if (sync_ok && state_q == ST_TSEG2) begin
        shr_n          = sjw_p1;
        sync_allowed_d = 1'b0;
      end
      ext_d = ext_n;
      shr_d = shr_n;
      if (tq_tick) begin
        case (state_q)
          ST_SYNC: begin
            state_d  = ST_TSEG1;
            tq_cnt_d = '0;
          end
          ST_TSEG1: begin
            if (tq_cnt_q == TQ_W'(tseg1_q) + ext_n) begin
              state_d        = ST_TSEG2;
              tq_cnt_d       = '0;
              sample_point_d = 1'b1;
              rx_bit_d       = rx_s;
              sync_allowed_d = 1'b1;
            end else begin
              tq_cnt_d = tq_cnt_q + 1'b1;
            end
          end
          ST_TSEG2: begin
            if (tq_cnt_q == TQ_W'(tseg2_q) - shr_n) enter_sync = 1'b1;
            else tq_cnt_d = tq_cnt_q + 1'b1;
          end
          default: state_d = ST_SYNC;
        endcase
      end
    end

    // Config only takes effect from the start of a bit
    if (enter_sync) begin
      state_d    = ST_SYNC;
      tq_cnt_d   = '0;
      ext_d      = '0;
      shr_d      = '0;
      tx_point_d = 1'b1;
      brp_d      = bus.cfg_brp;
      tseg1_d    = bus.cfg_tseg1;
      tseg2_d    = bus.cfg_tseg2;
      sjw_d      = bus.cfg_sjw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_SYNC;
      pcnt_q         <= '0;
      tq_cnt_q       <= '0;
      ext_q          <= '0;
      shr_q          <= '0;
      brp_q          <= DEF_BRP;
      tseg1_q        <= DEF_TSEG1;
      tseg2_q        <= DEF_TSEG2;
      sjw_q          <= DEF_SJW;
      sync_allowed_q <= 1'b1;
      sample_point_q <= 1'b0;
      tx_point_q     <= 1'b0;
      hard_sync_q    <= 1'b0;
      rx_bit_q       <= 1'b1;
    end else begin
      state_q        <= state_d;
      pcnt_q         <= pcnt_d;
      tq_cnt_q       <= tq_cnt_d;
      ext_q          <= ext_d;
      shr_q          <= shr_d;
      brp_q          <= brp_d;
      tseg1_q        <= tseg1_d;
      tseg2_q        <= tseg2_d;
      sjw_q          <= sjw_d;
      sync_allowed_q <= sync_allowed_d;
      sample_point_q <= sample_point_d;
      tx_point_q     <= tx_point_d;
      hard_sync_q    <= hard_sync_d;
      rx_bit_q       <= rx_bit_d;
    end
  end

  assign bus.sample_point = sample_point_q;
  assign bus.tx_point     = tx_point_q;
  assign bus.rx_bit       = rx_bit_q;
  assign bus.hard_sync    = hard_sync_q;

endmodule
